// File: rtl/pixel_write_scheduler_if.sv
// Bus bundle between the pixel write scheduler, the iterator array and the VGA SRAM port.
//   start               frame start request (level sampled)
//   req_valid/addr/color/done  per-iterator pixel requests, packed slice i = [i*W +: W]
//   grant               one-hot pulse: pixel i consumed
//   iter_start          pulse: iterators begin frame
//   vga_sram_*          registered write port
//   busy/frame_done/frame_cycles  frame status for the HPS
// The master modport is the scheduler; the slave modport is its environment.
interface pixel_write_scheduler_if #(
  parameter int unsigned N_ITER = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8
);
  logic                       start;
  logic [N_ITER-1:0]          req_valid;
  logic [N_ITER*ADDR_W-1:0]   req_addr;
  logic [N_ITER*DATA_W-1:0]   req_color;
  logic [N_ITER-1:0]          req_done;
  logic [N_ITER-1:0]          grant;
  logic                       iter_start;
  logic [ADDR_W-1:0]          vga_sram_address;
  logic [DATA_W-1:0]          vga_sram_writedata;
  logic                       vga_sram_write;
  logic                       busy;
  logic                       frame_done;
  logic [31:0]                frame_cycles;

  modport master (
    input  start, req_valid, req_addr, req_color, req_done,
    output grant, iter_start, vga_sram_address, vga_sram_writedata, vga_sram_write,
    output busy, frame_done, frame_cycles
  );

  modport slave (
    output start, req_valid, req_addr, req_color, req_done,
    input  grant, iter_start, vga_sram_address, vga_sram_writedata, vga_sram_write,
    input  busy, frame_done, frame_cycles
  );
endinterface

// File: rtl/pixel_write_scheduler.sv
// Round-robin scheduler sharing the single VGA SRAM write port among N_ITER iterators.
// Sequences a frame (IDLE -> START -> RUN -> DONE), grants one pending pixel per cycle
// with rotating priority, and reports completion plus RUN cycle count.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    pixel_write_scheduler_if.master (requests in, grants/SRAM write/status out)
module pixel_write_scheduler #(
  parameter int unsigned N_ITER = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  pixel_write_scheduler_if.master  bus
);

  localparam int unsigned PtrW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [PtrW-1:0] LastInit = PtrW'(N_ITER - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PtrW-1:0]   last_q, last_d;
  logic [N_ITER-1:0] grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       cycles_q, cycles_d;

  logic [N_ITER-1:0] eligible;
  logic              pick_valid;
  logic [PtrW-1:0]   pick_idx;
  logic [31:0]       cand;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_data;
  logic              all_done;

  // The requester granted this cycle is masked so it has one cycle to replace its pixel.
  assign eligible = bus.req_valid & ~grant_q;

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= N_ITER; off++) begin
      cand = 32'(last_q) + off;
      if (cand >= N_ITER) begin
        cand = cand - N_ITER;
      end
      if (!pick_valid && eligible[cand[PtrW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int unsigned i = 0; i < N_ITER; i++) begin
      if (pick_idx == PtrW'(i)) begin
        pick_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        pick_data = bus.req_color[i*DATA_W +: DATA_W];
      end
    end
  end

  // Frame ends only once nothing is pending and the last grant has retired.
  assign all_done = (&bus.req_done) && !(|bus.req_valid) && !(|grant_q);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = '0;
    write_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cycles_d = cycles_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StStart;
          cycles_d = '0;
        end
      end
      StStart: begin
        last_d  = LastInit;
        state_d = StRun;
      end
      StRun: begin
        if (cycles_q != 32'hFFFF_FFFF) begin
          cycles_d = cycles_q + 32'd1;
        end
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          write_d           = 1'b1;
          addr_d            = pick_addr;
          data_d            = pick_data;
          last_d            = pick_idx;
        end
        if (all_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Clearing the count on entry makes the restart visible alongside iter_start.
        if (bus.start) begin
          state_d  = StStart;
          cycles_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= LastInit;
      grant_q  <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.grant              = grant_q;
  assign bus.iter_start         = (state_q == StStart);
  assign bus.vga_sram_address   = addr_q;
  assign bus.vga_sram_writedata = data_q;
  assign bus.vga_sram_write     = write_q;
  assign bus.busy               = (state_q == StStart) || (state_q == StRun);
  assign bus.frame_done         = (state_q == StDone);
  assign bus.frame_cycles       = cycles_q;

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Bench for pixel_write_scheduler: directed table, hand sequences, random vs reference model.
module tb_pixel_write_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_write_scheduler_if #(.N_ITER(N), .ADDR_W(32), .DATA_W(8)) bus ();

  pixel_write_scheduler #(.N_ITER(N), .ADDR_W(32), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: 0 idle, 1 start, 2 run, 3 done.
  int          m_state;
  int          m_last;
  logic [3:0]  m_grant;
  logic        m_write;
  logic [31:0] m_addr;
  logic [7:0]  m_data;
  logic [31:0] m_cycles;

  typedef struct {
    logic       start;
    logic [3:0] valid;
    logic [3:0] done;
    logic [3:0] grant;
    logic       write;
    logic       istart;
    logic       busy;
    logic       fdone;
    int         cycles;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [31:0] addr_of(int k);
    return 32'h1000_0000 * (k + 1) + 32'h44 * k;
  endfunction

  function automatic logic [7:0] color_of(int k);
    return 8'h31 + 8'(8'h11 * k);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_vec();
    return {48'h0, bus.grant, bus.iter_start, bus.vga_sram_write, bus.busy, bus.frame_done,
            bus.vga_sram_address, bus.vga_sram_writedata, bus.frame_cycles};
  endfunction

  function automatic logic [127:0] model_vec();
    return {48'h0, m_grant, m_state == 1, m_write, (m_state == 1) || (m_state == 2),
            m_state == 3, m_addr, m_data, m_cycles};
  endfunction

  task automatic model_reset();
    m_state = 0; m_last = N - 1; m_grant = '0; m_write = 1'b0;
    m_addr = '0; m_data = '0; m_cycles = '0;
  endtask

  // Applied at each rising edge with the inputs the DUT samples there.
  task automatic model_step();
    bit exit_now;
    int pick;
    int k;
    case (m_state)
      0: begin
        m_grant = '0; m_write = 1'b0;
        if (bus.start) begin m_state = 1; m_cycles = '0; end
      end
      1: begin
        m_grant = '0; m_write = 1'b0; m_last = N - 1; m_state = 2;
      end
      2: begin
        exit_now = (bus.req_done == 4'hF) && (bus.req_valid == 4'h0) && (m_grant == 4'h0);
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        pick = -1;
        for (int j = 1; j <= N; j++) begin
          k = (m_last + j) % N;
          if (pick < 0 && bus.req_valid[k] && !m_grant[k]) pick = k;
        end
        if (pick >= 0) begin
          m_grant = 4'(1 << pick);
          m_write = 1'b1;
          m_addr  = bus.req_addr[pick*32 +: 32];
          m_data  = bus.req_color[pick*8 +: 8];
          m_last  = pick;
        end else begin
          m_grant = '0; m_write = 1'b0;
        end
        if (exit_now) m_state = 3;
      end
      default: begin
        m_grant = '0; m_write = 1'b0;
        if (bus.start) begin m_state = 1; m_cycles = '0; end
      end
    endcase
  endtask

  task automatic step(string name);
    @(posedge clk);
    model_step();
    #1;
    chk(name, dut_vec(), model_vec());
  endtask

  task automatic drive(logic s, logic [3:0] v, logic [3:0] d);
    bus.start = s; bus.req_valid = v; bus.req_done = d;
  endtask

  task automatic set_fixed_slices();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*32 +: 32] = addr_of(i);
      bus.req_color[i*8 +: 8]  = color_of(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'h0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), 128'h0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [7:0]  exp_data;
    int k;

    //               st  valid  done  grant w  is bz fd cyc
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1'b0, 4'hF, 4'h0, 4'h1, 1, 0, 1, 0, 1};
    vecs[3]  = '{1'b0, 4'hF, 4'h0, 4'h2, 1, 0, 1, 0, 2};
    vecs[4]  = '{1'b0, 4'hF, 4'h0, 4'h4, 1, 0, 1, 0, 3};
    vecs[5]  = '{1'b0, 4'hF, 4'h0, 4'h8, 1, 0, 1, 0, 4};
    vecs[6]  = '{1'b0, 4'hF, 4'h0, 4'h1, 1, 0, 1, 0, 5};
    vecs[7]  = '{1'b0, 4'hF, 4'h0, 4'h2, 1, 0, 1, 0, 6};
    vecs[8]  = '{1'b0, 4'hF, 4'h0, 4'h4, 1, 0, 1, 0, 7};
    vecs[9]  = '{1'b0, 4'hF, 4'h0, 4'h8, 1, 0, 1, 0, 8};
    vecs[10] = '{1'b0, 4'h4, 4'h0, 4'h4, 1, 0, 1, 0, 9};
    vecs[11] = '{1'b0, 4'h4, 4'h0, 4'h0, 0, 0, 1, 0, 10};
    vecs[12] = '{1'b0, 4'h4, 4'h0, 4'h4, 1, 0, 1, 0, 11};
    vecs[13] = '{1'b0, 4'h4, 4'h0, 4'h0, 0, 0, 1, 0, 12};
    vecs[14] = '{1'b0, 4'h4, 4'h0, 4'h4, 1, 0, 1, 0, 13};
    vecs[15] = '{1'b1, 4'h4, 4'h0, 4'h0, 0, 0, 1, 0, 14};
    vecs[16] = '{1'b0, 4'h4, 4'h0, 4'h4, 1, 0, 1, 0, 15};
    vecs[17] = '{1'b0, 4'h0, 4'hF, 4'h0, 0, 0, 1, 0, 16};
    vecs[18] = '{1'b0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 1, 17};
    vecs[19] = '{1'b0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 1, 17};
    vecs[20] = '{1'b1, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0, 0};

    bus.req_addr = '0;
    bus.req_color = '0;
    do_reset();
    set_fixed_slices();
    exp_addr = '0;
    exp_data = '0;

    // Directed table: start, 4-way rotation, single requester, start in RUN, finish, restart.
    for (int r = 0; r < 21; r++) begin
      drive(vecs[r].start, vecs[r].valid, vecs[r].done);
      step($sformatf("model_tbl%0d", r));
      if (vecs[r].grant != 4'h0) begin
        k = 0;
        for (int i = 0; i < N; i++) if (vecs[r].grant[i]) k = i;
        exp_addr = addr_of(k);
        exp_data = color_of(k);
      end
      chk($sformatf("tbl%0d", r),
          {48'h0, bus.grant, bus.vga_sram_write, bus.iter_start, bus.busy, bus.frame_done,
           bus.frame_cycles, bus.vga_sram_address, bus.vga_sram_writedata},
          {48'h0, vecs[r].grant, vecs[r].write, vecs[r].istart, vecs[r].busy, vecs[r].fdone,
           32'(vecs[r].cycles), exp_addr, exp_data});
    end

    // Exactly 100 RUN cycles, then completion and restart.
    drive(1'b0, 4'h0, 4'h0);
    step("run_enter");
    for (int c = 0; c < 98; c++) begin
      drive(1'b0, 4'($urandom), 4'h0);
      bus.req_addr = {$urandom, $urandom, $urandom, $urandom};
      bus.req_color = $urandom;
      step("run100");
    end
    drive(1'b0, 4'h0, 4'h0);
    step("run_drain");
    drive(1'b0, 4'h0, 4'hF);
    step("run_exit");
    chk("cycles_100", {95'h0, bus.frame_done, bus.frame_cycles}, {95'h0, 1'b1, 32'd100});
    for (int c = 0; c < 3; c++) begin
      step("done_idle");
      chk("done_hold", {95'h0, bus.vga_sram_write, bus.frame_cycles}, {95'h0, 1'b0, 32'd100});
    end
    drive(1'b1, 4'h0, 4'h0);
    step("restart");
    chk("restart", {94'h0, bus.iter_start, bus.frame_done, bus.frame_cycles},
        {94'h0, 1'b1, 1'b0, 32'd0});

    // Reset asserted while grant[1] is high.
    do_reset();
    set_fixed_slices();
    drive(1'b1, 4'h0, 4'h0);
    step("r5_start");
    drive(1'b0, 4'h2, 4'h0);
    step("r5_run");
    step("r5_grant");
    chk("r5_grant1", {124'h0, bus.grant}, {124'h0, 4'h2});
    #2 reset = 1'b1;
    #1;
    chk("reset_mid", dut_vec(), 128'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 4'hF, 4'h0);
    for (int c = 0; c < 3; c++) step("idle_no_grant");
    drive(1'b1, 4'hF, 4'h0);
    step("r5_restart");
    drive(1'b0, 4'hF, 4'h0);
    step("r5_run2");
    step("r5_first");
    chk("first_grant0", {124'h0, bus.grant}, {124'h0, 4'h1});

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.start = (r < 5);
      bus.req_valid = (r >= 80) ? 4'h0 : 4'($urandom);
      bus.req_done = (r >= 80) ? 4'hF : 4'($urandom);
      bus.req_addr = {$urandom, $urandom, $urandom, $urandom};
      bus.req_color = $urandom;
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
